i2c_xfer_seq: RTL and testbench
===============================

Name: i2c_xfer_seq

Overview:
- Multi-byte transfer sequencer sitting directly upstream of i2c_master.
- Accepts one host command (device address, direction, byte count), then drives i2c_master's ena/rd_wrt/addr/data_wrt handshake byte by byte. Fetches write bytes from the host via a request/valid handshake and returns read bytes with a one-cycle strobe.
- Turns the master's single-byte interface, with its continuation-on-same-address behaviour, into a counted burst with completion and error status.

Parameters:
LEN_W, 4, width of the byte-count field; max burst = 2**LEN_W-1 bytes.

Ports:
clk  in  1  system clock; everything on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle command strobe; sampled only in S_IDLE
rd_wrt  in  1  1 = read burst, 0 = write burst; latched on start
dev_addr  in  7  7-bit slave address; latched on start
len  in  LEN_W  byte count; latched on start; 0 = command ignored
wr_data  in  8  next write byte; captured when wr_req & wr_valid
wr_valid  in  1  host has wr_data ready
wr_req  out  1  level request for the next write byte
rd_data  out  8  last read byte
rd_valid  out  1  one-cycle strobe; rd_data updated this cycle
busy  out  1  high from accepted start until done/fault
done  out  1  one-cycle strobe at burst end (normal, underrun or fault)
underrun  out  1  set with done if host failed to supply a write byte in time; cleared on next accepted start
byte_cnt  out  LEN_W  bytes completed in current/last burst
err  out  1  sticky; master reported NACK; cleared only by reset
m_ena, m_rd_wrt, m_addr[6:0], m_data_wrt[7:0]  out  master command inputs
m_data_rd[7:0], m_busy, m_err  in  master outputs

Behaviour:
- Reset: all outputs 0, state S_IDLE, have_next=0, m_busy_d=0.
- m_busy_d registers m_busy. Rise = m_busy & ~m_busy_d; fall = ~m_busy & m_busy_d.
- m_addr/m_rd_wrt are driven from latched values for the entire burst, so the master's same-address continuation check always passes.
- S_IDLE: busy=0, m_ena=0. Accept a command on start & len!=0 & ~err: latch params, remaining=len, byte_cnt=0, underrun=0.
  - Write: go to S_FETCH0.
  - Read: go to S_LAUNCH.
  - start with len=0, or with err=1: ignored, no done.
- S_FETCH0: wr_req=1 until wr_valid. Then m_data_wrt<=wr_data; go to S_LAUNCH next cycle.
- S_LAUNCH: m_ena=1, held until rise is seen; then go to S_XFER. Holding covers the case where the master is still in its stop phases (busy low) from a previous burst.
- S_XFER: m_ena=0.
  - Prefetch: if write & remaining>1 & ~have_next, wr_req=1 until wr_valid. Then next_reg<=wr_data, have_next=1, wr_req drops in the following cycle.
  - On fall (byte + ack done):
    - Read: rd_data<=m_data_rd and rd_valid=1 in the cycle after fall.
    - remaining-1, byte_cnt+1.
    - If remaining becomes 0: done=1, go to S_IDLE with m_ena=0; the master issues stop.
    - Else if write & ~have_next: underrun=1, done=1, go to S_IDLE; the master issues stop after this byte.
    - Else go to S_CONT.
- S_CONT: m_ena=1, m_data_wrt<=next_reg (write), have_next<=0. Hold until rise, then go to S_XFER.
  - The master samples ena/data_wrt at the end of its ack half-period, many clk cycles after fall, so this response time is sufficient.
- m_err=1 in any state except S_IDLE/S_FAULT: go to S_FAULT next cycle; err=1, done=1 for one cycle, m_ena=0, wr_req=0.
- S_FAULT: busy=0, ignore start; exit only by reset, since the master also needs reset to leave its error state.
- start while busy: ignored.
- wr_valid outside wr_req: ignored.
- Reset mid-burst: immediate return to reset values; the master must be reset concurrently.

Test Plan:
- Write burst, addr=0x50, len=3, bytes A5,3C,FF supplied immediately, ACKing slave model -> slave sees 0xA0,A5,3C,FF then stop; one done; byte_cnt=3; err=0; underrun=0.
- Read burst, addr=0x48, len=2, slave returns 12,34 -> rd_valid pulses twice with rd_data 12 then 34; master ACKs byte 1; done; byte_cnt=2.
- Write len=3, host withholds second byte past first fall -> done with underrun=1, byte_cnt=1; stop issued; next start clears underrun.
- Write to absent slave (address NACK) -> err=1, done once, busy=0; subsequent start ignored until reset.
- start with len=0, and start during a burst -> no m_ena, no done, burst unaffected.
- Back-to-back: start issued the cycle after done -> m_ena held through the master's stop phases; second burst completes correctly.

Source files
------------

// File: rtl/i2c_xfer_seq.sv
// Burst sequencer in front of a single-byte I2C master: turns one host command into a
// counted run of master byte transfers, with write-byte prefetch and completion status.
module i2c_xfer_seq #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rd_wrt,
  input  logic [6:0]       dev_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_req,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic [LEN_W-1:0] byte_cnt,
  output logic             err,
  output logic             m_ena,
  output logic             m_rd_wrt,
  output logic [6:0]       m_addr,
  output logic [7:0]       m_data_wrt,
  input  logic [7:0]       m_data_rd,
  input  logic             m_busy,
  input  logic             m_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_LAUNCH, S_XFER, S_CONT, S_FAULT
  } state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] remaining_reg;
  logic [7:0]       next_reg;
  logic             have_next;
  logic             m_busy_d;

  logic rise, fall, got_byte, want_next;

  assign rise      = m_busy & ~m_busy_d;
  assign fall      = ~m_busy & m_busy_d;
  // wr_req is only ever raised while a byte is wanted, so a handshake here is always a capture.
  assign got_byte  = wr_req & wr_valid;
  assign want_next = ~m_rd_wrt & (remaining_reg > LEN_W'(1)) & ~have_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      remaining_reg <= '0;
      next_reg      <= '0;
      have_next     <= 1'b0;
      m_busy_d      <= 1'b0;
      wr_req        <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      underrun      <= 1'b0;
      byte_cnt      <= '0;
      err           <= 1'b0;
      m_ena         <= 1'b0;
      m_rd_wrt      <= 1'b0;
      m_addr        <= '0;
      m_data_wrt    <= '0;
    end else begin
      m_busy_d <= m_busy;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      if (m_err && state_reg != S_IDLE && state_reg != S_FAULT) begin
        state_reg <= S_FAULT;
        err       <= 1'b1;
        done      <= 1'b1;
        busy      <= 1'b0;
        m_ena     <= 1'b0;
        wr_req    <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            busy   <= 1'b0;
            m_ena  <= 1'b0;
            wr_req <= 1'b0;
            if (start && len != '0 && !err) begin
              m_addr        <= dev_addr;
              m_rd_wrt      <= rd_wrt;
              remaining_reg <= len;
              byte_cnt      <= '0;
              underrun      <= 1'b0;
              have_next     <= 1'b0;
              busy          <= 1'b1;
              if (rd_wrt) begin
                m_ena     <= 1'b1;
                state_reg <= S_LAUNCH;
              end else begin
                wr_req    <= 1'b1;
                state_reg <= S_FETCH0;
              end
            end
          end
          S_FETCH0: begin
            if (got_byte) begin
              m_data_wrt <= wr_data;
              wr_req     <= 1'b0;
              m_ena      <= 1'b1;
              state_reg  <= S_LAUNCH;
            end else begin
              wr_req <= 1'b1;
            end
          end
          // Shared by first launch and continuation: hold ena until the master picks it up,
          // which also rides out a previous burst's stop phase.
          S_LAUNCH, S_CONT: begin
            m_ena <= 1'b1;
            if (rise) begin
              m_ena     <= 1'b0;
              state_reg <= S_XFER;
            end
          end
          S_XFER: begin
            m_ena <= 1'b0;
            if (fall) begin
              remaining_reg <= remaining_reg - LEN_W'(1);
              byte_cnt      <= byte_cnt + LEN_W'(1);
              wr_req        <= 1'b0;
              if (m_rd_wrt) begin
                rd_data  <= m_data_rd;
                rd_valid <= 1'b1;
              end
              if (remaining_reg == LEN_W'(1)) begin
                done      <= 1'b1;
                busy      <= 1'b0;
                state_reg <= S_IDLE;
              end else if (!m_rd_wrt && !have_next && !got_byte) begin
                underrun  <= 1'b1;
                done      <= 1'b1;
                busy      <= 1'b0;
                state_reg <= S_IDLE;
              end else begin
                m_ena     <= 1'b1;
                have_next <= 1'b0;
                if (!m_rd_wrt) m_data_wrt <= got_byte ? wr_data : next_reg;
                state_reg <= S_CONT;
              end
            end else if (got_byte) begin
              next_reg  <= wr_data;
              have_next <= 1'b1;
              wr_req    <= 1'b0;
            end else if (want_next) begin
              wr_req <= 1'b1;
            end
          end
          S_FAULT: begin
            busy   <= 1'b0;
            m_ena  <= 1'b0;
            wr_req <= 1'b0;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Bench for i2c_xfer_seq: behavioural single-byte I2C master plus slave, a host byte feeder,
// and scoreboards for bus events and read-data strobes.
module tb_i2c_xfer_seq;
  localparam int LEN_W     = 4;
  localparam int BYTE_CYC  = 6;
  localparam int ACK_CYC   = 2;
  localparam int STOP_CYC  = 8;
  localparam int EV_STOP   = 256;
  localparam int EV_ACK    = 257;
  localparam int EV_NACK   = 258;
  localparam int M_IDLE = 0, M_ADDR = 1, M_DATA = 2, M_ACK = 3, M_STOP = 4, M_ERR = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             rd_wrt = 1'b0;
  logic [6:0]       dev_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic [7:0]       wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_req, rd_valid, busy, done, underrun, err;
  logic [7:0]       rd_data;
  logic [LEN_W-1:0] byte_cnt;
  logic             m_ena, m_rd_wrt;
  logic [6:0]       m_addr;
  logic [7:0]       m_data_wrt;
  logic [7:0]       m_data_rd;
  logic             m_busy, m_err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int ena_cnt = 0;
  int ena_in_stop = 0;
  int rd_cnt = 0;
  int exp_bus_q[$];
  int exp_rd_q[$];
  int slave_rd_q[$];
  int host_q[$];
  int host_allow = 1000;

  always #5 clk = ~clk;

  i2c_xfer_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_wrt(rd_wrt), .dev_addr(dev_addr),
    .len(len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_req(wr_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .underrun(underrun), .byte_cnt(byte_cnt), .err(err), .m_ena(m_ena),
    .m_rd_wrt(m_rd_wrt), .m_addr(m_addr), .m_data_wrt(m_data_wrt),
    .m_data_rd(m_data_rd), .m_busy(m_busy), .m_err(m_err)
  );

  task automatic bus_event(input int v);
    int e;
    total++;
    if (exp_bus_q.size() == 0) begin
      bad++;
      $display("FAIL bus_event: observed %0h, expected no event", v);
    end else begin
      e = exp_bus_q.pop_front();
      if (v !== e) begin
        bad++;
        $display("FAIL bus_event: observed %0h, expected %0h", v, e);
      end
    end
  endtask

  // Master model: busy high over address/data, low through ack and stop; ena sampled in idle
  // and at the end of the ack phase, where same address/direction means continuation.
  int         ms = M_IDLE;
  int         mcnt = 0;
  logic [6:0] ma = '0;
  logic       mrw = 1'b0;
  wire        m_cont = m_ena && (m_addr == ma) && (m_rd_wrt == mrw);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms <= M_IDLE; mcnt <= 0; m_busy <= 1'b0; m_err <= 1'b0; m_data_rd <= '0;
      ma <= '0; mrw <= 1'b0;
    end else begin
      case (ms)
        M_IDLE: if (m_ena) begin
          ma <= m_addr; mrw <= m_rd_wrt; m_busy <= 1'b1; mcnt <= BYTE_CYC; ms <= M_ADDR;
          bus_event(int'({m_addr, m_rd_wrt}));
        end
        M_ADDR: if (mcnt > 1) mcnt <= mcnt - 1;
          else if (ma != 7'h50 && ma != 7'h48) begin
            m_err <= 1'b1; m_busy <= 1'b0; ms <= M_ERR;
          end else begin
            mcnt <= BYTE_CYC; ms <= M_DATA;
            if (!mrw) bus_event(int'(m_data_wrt));
          end
        M_DATA: if (mcnt > 1) mcnt <= mcnt - 1;
          else begin
            m_busy <= 1'b0; mcnt <= ACK_CYC; ms <= M_ACK;
            if (mrw) begin
              if (slave_rd_q.size() > 0) m_data_rd <= 8'(slave_rd_q.pop_front());
              else m_data_rd <= 8'hEE;
            end
          end
        M_ACK: if (mcnt > 1) mcnt <= mcnt - 1;
          else begin
            if (mrw) bus_event(m_cont ? EV_ACK : EV_NACK);
            if (m_cont) begin
              m_busy <= 1'b1; mcnt <= BYTE_CYC; ms <= M_DATA;
              if (!mrw) bus_event(int'(m_data_wrt));
            end else begin
              mcnt <= STOP_CYC; ms <= M_STOP;
            end
          end
        M_STOP: if (mcnt > 1) mcnt <= mcnt - 1;
          else begin
            bus_event(EV_STOP); ms <= M_IDLE;
          end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (done) done_cnt++;
      if (m_ena) ena_cnt++;
      if (m_ena && ms == M_STOP) ena_in_stop++;
      if (rd_valid) begin
        rd_cnt++;
        total++;
        if (exp_rd_q.size() == 0) begin
          bad++;
          $display("FAIL rd_data: observed %0h, expected no strobe", rd_data);
        end else if (int'(rd_data) !== exp_rd_q[0]) begin
          bad++;
          $display("FAIL rd_data: observed %0h, expected %0h", rd_data, exp_rd_q[0]);
          void'(exp_rd_q.pop_front());
        end else begin
          void'(exp_rd_q.pop_front());
        end
      end
    end
  end

  // Host: offers the next queued byte while wr_req is up; the DUT takes it on the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_valid) begin
        wr_valid = 1'b0;
        if (host_q.size() > 0) void'(host_q.pop_front());
      end else if (wr_req && host_q.size() > 0 && host_allow > 0) begin
        wr_data  = 8'(host_q[0]);
        wr_valid = 1'b1;
        host_allow--;
      end
    end
  end

  task automatic cmd(input logic rw, input logic [6:0] a, input logic [LEN_W-1:0] l);
    @(negedge clk);
    rd_wrt = rw; dev_addr = a; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done=1", name, n);
    end
  endtask

  task automatic wait_master_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ms != M_IDLE && n < 400);
    total++;
    if (exp_bus_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_bus_left: %0d bus events still expected, required 0", name, exp_bus_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({wr_req, rd_data, rd_valid, busy, done, underrun, byte_cnt, err, m_ena, m_rd_wrt,
         m_addr, m_data_wrt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: some output nonzero (busy=%b m_ena=%b err=%b), required all 0",
               busy, m_ena, err);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || m_ena !== 1'b0 || wr_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b m_ena=%b wr_req=%b, required 0 0 0", busy, m_ena, wr_req);
    end
  endtask

  task automatic test_write_burst();
    int d0 = done_cnt;
    exp_bus_q = '{8'hA0, 8'hA5, 8'h3C, 8'hFF, EV_STOP};
    host_q = '{8'hA5, 8'h3C, 8'hFF};
    host_allow = 1000;
    cmd(1'b0, 7'h50, 4'd3);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL write_busy: busy=%b, required 1", busy);
    end
    wait_done("write");
    total++;
    if (byte_cnt !== 4'd3 || err !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL write_status: byte_cnt=%0d err=%b underrun=%b, required 3 0 0", byte_cnt, err, underrun);
    end
    wait_master_idle("write");
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++; $display("FAIL write_done_count: %0d done pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_read_burst();
    int d0 = done_cnt;
    int r0 = rd_cnt;
    slave_rd_q = '{8'h12, 8'h34};
    exp_rd_q = '{8'h12, 8'h34};
    exp_bus_q = '{8'h91, EV_ACK, EV_NACK, EV_STOP};
    cmd(1'b1, 7'h48, 4'd2);
    wait_done("read");
    @(negedge clk);
    total++;
    if (byte_cnt !== 4'd2 || busy !== 1'b0) begin
      bad++; $display("FAIL read_status: byte_cnt=%0d busy=%b, required 2 0", byte_cnt, busy);
    end
    wait_master_idle("read");
    total++;
    if (rd_cnt - r0 !== 2 || done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL read_counts: rd_valid=%0d done=%0d, required 2 1", rd_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_underrun();
    int d0 = done_cnt;
    exp_bus_q = '{8'hA0, 8'hA1, EV_STOP};
    host_q = '{8'hA1, 8'hB2, 8'hC3};
    host_allow = 1;
    cmd(1'b0, 7'h50, 4'd3);
    wait_done("underrun");
    total++;
    if (underrun !== 1'b1 || byte_cnt !== 4'd1) begin
      bad++;
      $display("FAIL underrun_status: underrun=%b byte_cnt=%0d, required 1 1", underrun, byte_cnt);
    end
    wait_master_idle("underrun");
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++; $display("FAIL underrun_done_count: %0d, required 1", done_cnt - d0);
    end
    host_q.delete();
    host_allow = 1000;
    host_q = '{8'h5A};
    exp_bus_q = '{8'hA0, 8'h5A, EV_STOP};
    cmd(1'b0, 7'h50, 4'd1);
    total++;
    if (underrun !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL underrun_clear: underrun=%b busy=%b, required 0 1", underrun, busy);
    end
    wait_done("underrun_next");
    total++;
    if (underrun !== 1'b0 || byte_cnt !== 4'd1) begin
      bad++;
      $display("FAIL underrun_next_status: underrun=%b byte_cnt=%0d, required 0 1", underrun, byte_cnt);
    end
    wait_master_idle("underrun_next");
  endtask

  task automatic test_ignored_starts();
    int d0 = done_cnt;
    int e0 = ena_cnt;
    cmd(1'b0, 7'h50, 4'd0);
    repeat (20) @(negedge clk);
    total++;
    if (ena_cnt - e0 !== 0 || done_cnt - d0 !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL len0_ignored: m_ena cycles=%0d done=%0d busy=%b, required 0 0 0",
               ena_cnt - e0, done_cnt - d0, busy);
    end
    slave_rd_q = '{8'h5C};
    exp_rd_q = '{8'h5C};
    exp_bus_q = '{8'h91, EV_NACK, EV_STOP};
    cmd(1'b1, 7'h48, 4'd1);
    repeat (4) @(negedge clk);
    cmd(1'b0, 7'h50, 4'd5);
    wait_done("busy_start");
    @(negedge clk);
    total++;
    if (byte_cnt !== 4'd1 || m_addr !== 7'h48 || m_rd_wrt !== 1'b1) begin
      bad++;
      $display("FAIL busy_start_ignored: byte_cnt=%0d m_addr=%h m_rd_wrt=%b, required 1 48 1",
               byte_cnt, m_addr, m_rd_wrt);
    end
    wait_master_idle("busy_start");
    total++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_start_done: done=%0d busy=%b, required 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    ena_in_stop = 0;
    host_q = '{8'h11, 8'h22};
    slave_rd_q = '{8'h77};
    exp_rd_q = '{8'h77};
    exp_bus_q = '{8'hA0, 8'h11, 8'h22, EV_STOP, 8'h91, EV_NACK, EV_STOP};
    cmd(1'b0, 7'h50, 4'd2);
    wait_done("b2b_first");
    cmd(1'b1, 7'h48, 4'd1);
    wait_done("b2b_second");
    @(negedge clk);
    total++;
    if (byte_cnt !== 4'd1 || underrun !== 1'b0) begin
      bad++; $display("FAIL b2b_status: byte_cnt=%0d underrun=%b, required 1 0", byte_cnt, underrun);
    end
    wait_master_idle("b2b");
    total++;
    if (ena_in_stop == 0 || done_cnt - d0 !== 2) begin
      bad++;
      $display("FAIL b2b_hold: m_ena cycles in stop=%0d done=%0d, required >0 and 2",
               ena_in_stop, done_cnt - d0);
    end
  endtask

  task automatic test_nack();
    int d0 = done_cnt;
    int e0;
    exp_bus_q = '{8'h44};
    host_q = '{8'h99};
    cmd(1'b0, 7'h22, 4'd2);
    wait_done("nack");
    @(negedge clk);
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || m_ena !== 1'b0 || wr_req !== 1'b0) begin
      bad++;
      $display("FAIL nack_status: err=%b busy=%b m_ena=%b wr_req=%b, required 1 0 0 0",
               err, busy, m_ena, wr_req);
    end
    e0 = ena_cnt;
    cmd(1'b1, 7'h48, 4'd1);
    repeat (30) @(negedge clk);
    total++;
    if (ena_cnt - e0 !== 0 || done_cnt - d0 !== 1 || busy !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL fault_ignores_start: m_ena cycles=%0d done=%0d busy=%b err=%b, required 0 1 0 1",
               ena_cnt - e0, done_cnt - d0, busy, err);
    end
    total++;
    if (exp_bus_q.size() !== 0) begin
      bad++; $display("FAIL nack_bus_left: %0d events pending, required 0", exp_bus_q.size());
    end
    host_q.delete();
    exp_rd_q.delete();
    slave_rd_q.delete();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (err !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_clears_err: err=%b done=%b, required 0 0", err, done);
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_underrun();
    test_ignored_starts();
    test_back_to_back();
    test_nack();
    total++;
    if (exp_rd_q.size() !== 0) begin
      bad++; $display("FAIL rd_left: %0d read bytes never strobed, required 0", exp_rd_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
